hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 16-bit five-stage processor. It generates the stall and flush strobes for the IF, IF/ID, ID/EX and EX/MEM pipeline registers. It covers load-use hazards, taken branches, jumps, multi-cycle floating-point operations in EX and the Stop drain/halt sequence. It sits beside the datapath and drives the `stall_ID_EX_i` / `flush_ID_EX_i` inputs of the ID stage and the equivalent controls of the other stages.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch, jump, multi-cycle FP and Stop drain/halt.
// Optional stall-cycle counter is built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int REG_WIDTH = 4,
    parameter int FP_LAT    = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] rsD,
    input  logic [REG_WIDTH-1:0] rtD,
    input  logic [REG_WIDTH-1:0] rtE,
    input  logic                 MemReadE,
    input  logic                 PCSrcE,
    input  logic                 JumpD,
    input  logic                 FloatingE,
    input  logic                 StopE,
    output logic                 stall_IF_o,
    output logic                 stall_IF_ID_o,
    output logic                 flush_IF_ID_o,
    output logic                 stall_ID_EX_o,
    output logic                 flush_ID_EX_o,
    output logic                 flush_EX_MEM_o,
    output logic                 halted_o,
    output logic [15:0]          stall_cnt_o
);

    typedef enum logic [1:0] {RUN, FP_BUSY, DRAIN, HALT} state_t;

    localparam logic [CNT_WIDTH-1:0] FP_INIT = CNT_WIDTH'(FP_LAT - 2);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [1:0]           dcnt, dcnt_nxt;
    logic                 load_use;

    assign load_use = MemReadE && ((rtE == rsD) || (rtE == rtD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        dcnt_nxt       = dcnt;
        stall_IF_o     = 1'b0;
        stall_IF_ID_o  = 1'b0;
        flush_IF_ID_o  = 1'b0;
        stall_ID_EX_o  = 1'b0;
        flush_ID_EX_o  = 1'b0;
        flush_EX_MEM_o = 1'b0;
        halted_o       = 1'b0;
        if (!rst) begin
            // Bubbles everywhere while reset is held, independent of state.
            flush_IF_ID_o  = 1'b1;
            flush_ID_EX_o  = 1'b1;
            flush_EX_MEM_o = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (StopE) begin
                        stall_IF_o    = 1'b1;
                        flush_IF_ID_o = 1'b1;
                        flush_ID_EX_o = 1'b1;
                        state_nxt     = DRAIN;
                        dcnt_nxt      = 2'd1;
                    end else if (PCSrcE) begin
                        flush_IF_ID_o = 1'b1;
                        flush_ID_EX_o = 1'b1;
                    end else if (FloatingE) begin
                        stall_IF_o     = 1'b1;
                        stall_IF_ID_o  = 1'b1;
                        stall_ID_EX_o  = 1'b1;
                        flush_EX_MEM_o = 1'b1;
                        state_nxt      = FP_BUSY;
                        cnt_nxt        = FP_INIT;
                    end else if (load_use) begin
                        // A simultaneous jump is dropped; it re-decodes after the stall.
                        stall_IF_o    = 1'b1;
                        stall_IF_ID_o = 1'b1;
                        flush_ID_EX_o = 1'b1;
                    end else if (JumpD) begin
                        flush_IF_ID_o = 1'b1;
                    end
                end
                FP_BUSY: begin
                    if (cnt != '0) begin
                        stall_IF_o     = 1'b1;
                        stall_IF_ID_o  = 1'b1;
                        stall_ID_EX_o  = 1'b1;
                        flush_EX_MEM_o = 1'b1;
                        cnt_nxt        = cnt - CNT_WIDTH'(1);
                    end else begin
                        state_nxt = RUN;
                    end
                end
                DRAIN: begin
                    stall_IF_o    = 1'b1;
                    flush_IF_ID_o = 1'b1;
                    flush_ID_EX_o = 1'b1;
                    if (dcnt == 2'd0) state_nxt = HALT;
                    else              dcnt_nxt  = dcnt - 2'd1;
                end
                default: begin
                    halted_o      = 1'b1;
                    stall_IF_o    = 1'b1;
                    stall_IF_ID_o = 1'b1;
                    stall_ID_EX_o = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall_IF_o && (state != HALT) && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: combinational vector table, hand-written multi-cycle sequences,
// then randomized traffic against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rsD = '0, rtD = '0, rtE = '0;
    logic        MemReadE = 0, PCSrcE = 0, JumpD = 0, FloatingE = 0, StopE = 0;

    logic        stall_IF, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, flush_EX_MEM, halted;
    logic [15:0] stall_cnt;
    logic        d2_sIF, d2_sIFID, d2_fIFID, d2_sIDEX, d2_fIDEX, d2_fEXMEM, d2_halted;
    logic [15:0] d2_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining EX cycles of the current FP op, cycles since Stop, stall count.
    int m_fp_left = 0;
    int m_stop_age = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_WIDTH(4), .FP_LAT(LAT), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rtE(rtE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .JumpD(JumpD), .FloatingE(FloatingE), .StopE(StopE),
        .stall_IF_o(stall_IF), .stall_IF_ID_o(stall_IF_ID), .flush_IF_ID_o(flush_IF_ID),
        .stall_ID_EX_o(stall_ID_EX), .flush_ID_EX_o(flush_ID_EX), .flush_EX_MEM_o(flush_EX_MEM),
        .halted_o(halted), .stall_cnt_o(stall_cnt)
    );

    hazard_ctrl #(.REG_WIDTH(4), .FP_LAT(2), .CNT_WIDTH(3)) dut2 (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rtE(rtE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .JumpD(JumpD), .FloatingE(FloatingE), .StopE(StopE),
        .stall_IF_o(d2_sIF), .stall_IF_ID_o(d2_sIFID), .flush_IF_ID_o(d2_fIFID),
        .stall_ID_EX_o(d2_sIDEX), .flush_ID_EX_o(d2_fIDEX), .flush_EX_MEM_o(d2_fEXMEM),
        .halted_o(d2_halted), .stall_cnt_o(d2_cnt)
    );

    typedef struct {
        logic       mr, pc, jd, fl, st;
        logic [3:0] rs, rt, rte;
        logic [5:0] exp;   // {sIF, sIFID, fIFID, sIDEX, fIDEX, fEXMEM}
    } vec_t;

    vec_t tbl[13];

    function automatic logic [6:0] act_vec();
        return {halted, stall_IF, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, flush_EX_MEM};
    endfunction

    function automatic logic [6:0] d2_vec();
        return {d2_halted, d2_sIF, d2_sIFID, d2_fIFID, d2_sIDEX, d2_fIDEX, d2_fEXMEM};
    endfunction

    function automatic logic [6:0] model_exp();
        logic lu;
        lu = MemReadE && (rtE == rsD || rtE == rtD);
        if (!rst)                 return 7'b0_001011;
        else if (m_stop_age >= 3) return 7'b1_110100;
        else if (m_stop_age >= 1) return 7'b0_101010;
        else if (m_fp_left > 1)   return 7'b0_110101;
        else if (m_fp_left == 1)  return 7'b0_000000;
        else if (StopE)           return 7'b0_101010;
        else if (PCSrcE)          return 7'b0_001010;
        else if (FloatingE)       return 7'b0_110101;
        else if (lu)              return 7'b0_110010;
        else if (JumpD)           return 7'b0_001000;
        return 7'b0_000000;
    endfunction

    function automatic int exp_cnt();
`ifdef HAZARD_PERF_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_fp_left = 0; m_stop_age = 0; m_cnt = 0;
    endtask

    task automatic model_update();
        logic [6:0] e;
        if (!rst) begin
            model_reset();
        end else begin
            e = model_exp();
            if (e[5] && m_stop_age < 3 && m_cnt < 65535) m_cnt++;
            if (m_stop_age >= 1 && m_stop_age < 3) m_stop_age++;
            else if (m_stop_age == 0) begin
                if (m_fp_left > 0)               m_fp_left--;
                else if (StopE)                  m_stop_age = 1;
                else if (!PCSrcE && FloatingE)   m_fp_left = LAT - 1;
            end
        end
    endtask

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input int exp);
        checks++;
        if (act !== 16'(exp)) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic mr, pc, jd, fl, st, input logic [3:0] rs, rt, rte);
        MemReadE = mr; PCSrcE = pc; JumpD = jd; FloatingE = fl; StopE = st;
        rsD = rs; rtD = rt; rtE = rte;
    endtask

    task automatic check_now();
        check7("strobes", act_vec(), model_exp());
        check16("stall_cnt", stall_cnt, exp_cnt());
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step(input logic mr, pc, jd, fl, st, input logic [3:0] rs, rt, rte);
        drive(mr, pc, jd, fl, st, rs, rt, rte);
        #2;
        check_now();
        tick();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2);
        rst = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [6:0] d2_exp[5];
        tbl[0]  = '{0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2, 6'b000000};
        tbl[1]  = '{1, 0, 0, 0, 0, 4'd3, 4'd5, 4'd3, 6'b110010};
        tbl[2]  = '{1, 0, 0, 0, 0, 4'd1, 4'd5, 4'd5, 6'b110010};
        tbl[3]  = '{1, 0, 0, 0, 0, 4'd4, 4'd5, 4'd3, 6'b000000};
        tbl[4]  = '{0, 0, 0, 0, 0, 4'd3, 4'd3, 4'd3, 6'b000000};
        tbl[5]  = '{1, 1, 0, 0, 0, 4'd3, 4'd5, 4'd3, 6'b001010};
        tbl[6]  = '{0, 0, 1, 0, 0, 4'd0, 4'd1, 4'd2, 6'b001000};
        tbl[7]  = '{1, 0, 1, 0, 0, 4'd3, 4'd5, 4'd3, 6'b110010};
        tbl[8]  = '{0, 0, 0, 1, 0, 4'd0, 4'd1, 4'd2, 6'b110101};
        tbl[9]  = '{1, 0, 0, 1, 0, 4'd3, 4'd5, 4'd3, 6'b110101};
        tbl[10] = '{0, 1, 0, 1, 0, 4'd0, 4'd1, 4'd2, 6'b001010};
        tbl[11] = '{0, 0, 0, 0, 1, 4'd0, 4'd1, 4'd2, 6'b101010};
        tbl[12] = '{1, 1, 1, 1, 1, 4'd3, 4'd5, 4'd3, 6'b101010};

        // Reset state, observed while rst is still low.
        #2;
        check7("reset_out", act_vec(), 7'b0_001011);
        check16("reset_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // Combinational decode from RUN: no clock edges between rows.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].mr, tbl[i].pc, tbl[i].jd, tbl[i].fl, tbl[i].st, tbl[i].rs, tbl[i].rt, tbl[i].rte);
            #1;
            check7($sformatf("table_%0d", i), act_vec(), {1'b0, tbl[i].exp});
        end

        // Load-use: exactly one stall cycle.
        do_reset();
        step(1, 0, 0, 0, 0, 4'd3, 4'd5, 4'd3);
        step(0, 0, 0, 0, 0, 4'd3, 4'd5, 4'd3);
        check7("lu_one_cycle", act_vec(), 7'b0);

        // FP timing: LAT=4 on dut (model), LAT=2 on dut2 (explicit), FloatingE held 4 cycles.
        do_reset();
        d2_exp[0] = 7'b0_110101; d2_exp[1] = 7'b0_000000;
        d2_exp[2] = 7'b0_110101; d2_exp[3] = 7'b0_000000;
        d2_exp[4] = 7'b0_110010;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, 1'b0, 0, 1, 0, 4'd0, 4'd1, 4'd2);
            else       drive(1, 0, 0, 0, 0, 4'd2, 4'd1, 4'd2);
            #2;
            check_now();
            check7($sformatf("fp2_cycle%0d", i), d2_vec(), d2_exp[i]);
            tick();
        end
`ifdef HAZARD_PERF_CNT_EN
        check16("fp2_cnt", d2_cnt, 3);
`else
        check16("fp2_cnt", d2_cnt, 0);
`endif

        // Stop: drain 3 cycles then halt, ignoring branch/FP.
        do_reset();
        step(0, 0, 0, 0, 1, 4'd0, 4'd1, 4'd2);
        step(0, 1, 0, 1, 0, 4'd0, 4'd1, 4'd2);
        step(0, 1, 0, 1, 0, 4'd0, 4'd1, 4'd2);
        #2;
        check7("halt_entry", act_vec(), 7'b1_110100);
`ifdef HAZARD_PERF_CNT_EN
        check16("halt_cnt", stall_cnt, 3);
`else
        check16("halt_cnt", stall_cnt, 0);
`endif
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 1, 4'd3, 4'd3, 4'd3);

        // Asynchronous reset in FP_BUSY with cnt=1.
        do_reset();
        step(0, 0, 0, 1, 0, 4'd0, 4'd1, 4'd2);
        step(0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2);
        rst = 1'b0;
        #1;
        check7("async_rst", act_vec(), 7'b0_001011);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2);
        check16("post_rst_cnt", stall_cnt, 0);
        step(1, 0, 0, 0, 0, 4'd6, 4'd7, 4'd6);

        // Randomized traffic with occasional Stop and reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
